horner_sequencer: RTL and testbench

- Control sequencer for the polynomial-approximation MAC datapath. Evaluates p(x) by Horner's rule: acc = c[ORDER], then acc = acc*x + c[k] for k = ORDER-1 down to 0.
- Pops x samples from the input FIFO and drives coefficient-ROM addresses and the MAC load/enable strobes.
- Paces issue to the MAC pipeline latency and presents each result with a valid/ready handshake.
- Sits between the input FIFO, the coefficient ROM and the MAC unit; it touches control only, never data.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/horner_sequencer.sv | 122 ++++++++++++
 tb/tb_horner_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the polynomial MAC control path: FSM encoding,
// default geometry, and the coefficient-ROM address packing used by sequencer and ROM.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_e;

    localparam int ORDER_DEF   = 4;
    localparam int MAC_LAT_DEF = 2;
    localparam int FUNC_W_DEF  = 2;
    localparam int IDX_W_DEF   = 3;

    // ROM address is {func, idx}; callers keep the low FUNC_W+IDX_W bits.
    function automatic logic [31:0] pack_coeff_addr(input logic [31:0] func,
                                                    input logic [31:0] idx,
                                                    input int unsigned idx_w);
        return (func << idx_w) | idx;
    endfunction

endpackage

// File: rtl/horner_sequencer.sv
// Horner-rule control sequencer: pops x, walks coefficients from ORDER down to 0,
// spaces MAC issues by MAC_LAT and hands the result off with valid/ready.
module horner_sequencer
    import mac_pkg::*;
#(
    parameter int ORDER   = ORDER_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int FUNC_W  = FUNC_W_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic [FUNC_W-1:0]       func_sel,
    output logic [FUNC_W+IDX_W-1:0] coeff_addr,
    output logic                    ld_signal,
    output logic                    ld_coeff,
    output logic                    acc_init,
    output logic                    mac_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int ADDR_W    = FUNC_W + IDX_W;
    localparam int CNT_W     = 4;
    // One of the MAC_LAT cycles is the ISSUE cycle itself, another is the final WAIT at count 0.
    localparam int WAIT_INIT = (MAC_LAT > 1) ? MAC_LAT - 2 : 0;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [FUNC_W-1:0]   func_q, func_d;

    logic                pop;
    logic [IDX_W-1:0]    addr_idx;
    logic [31:0]         addr_full;
    logic [31-ADDR_W:0]  unused_addr_hi;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        func_d    = func_q;
        pop       = 1'b0;
        addr_idx  = idx_q;
        ld_signal = 1'b0;
        ld_coeff  = 1'b0;
        acc_init  = 1'b0;
        mac_en    = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            S_LOAD: begin
                ld_signal = 1'b1;
                ld_coeff  = 1'b1;
                acc_init  = 1'b1;
                addr_idx  = IDX_W'(ORDER);
                idx_d     = IDX_W'(ORDER - 1);
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                mac_en   = 1'b1;
                ld_coeff = 1'b1;
                if (MAC_LAT == 1) begin
                    if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
                    else             state_d = S_OUT;
                end else begin
                    wcnt_d  = CNT_W'(WAIT_INIT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            func_d  = func_sel;
            state_d = S_LOAD;
        end

        fifo_pop  = pop & ~rst;
        busy      = (state_q != S_IDLE);
        addr_full = pack_coeff_addr(32'(func_q), 32'(addr_idx), IDX_W);
        {unused_addr_hi, coeff_addr} = addr_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            func_q  <= func_d;
        end
    end

endmodule

// File: tb/tb_horner_sequencer.sv
// Directed bench for horner_sequencer: cycle table for one sample, a MAC_LAT=1 stream,
// backpressure with func_sel capture, mid-operation reset and an idle FIFO.
module tb_horner_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty, out_ready;
    logic [1:0] func_sel;
    logic       fifo_pop, ld_signal, ld_coeff, acc_init, mac_en, out_valid, busy;
    logic [4:0] coeff_addr;

    logic       fifo_empty2, out_ready2;
    logic [1:0] func_sel2;
    logic       fifo_pop2, ld_signal2, ld_coeff2, acc_init2, mac_en2, out_valid2, busy2;
    logic [4:0] coeff_addr2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    horner_sequencer #(.ORDER(4), .MAC_LAT(2), .FUNC_W(2), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .func_sel(func_sel), .coeff_addr(coeff_addr), .ld_signal(ld_signal),
        .ld_coeff(ld_coeff), .acc_init(acc_init), .mac_en(mac_en),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    horner_sequencer #(.ORDER(3), .MAC_LAT(1), .FUNC_W(2), .IDX_W(3)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_pop(fifo_pop2),
        .func_sel(func_sel2), .coeff_addr(coeff_addr2), .ld_signal(ld_signal2),
        .ld_coeff(ld_coeff2), .acc_init(acc_init2), .mac_en(mac_en2),
        .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
    );

    logic [6:0] flags;
    assign flags = {fifo_pop, ld_signal, ld_coeff, acc_init, mac_en, out_valid, busy};

    typedef struct {
        logic       empty;
        logic [6:0] flags;
        int         addr;
    } vec_t;

    // Bench ROM: func 2 holds c[k]=k+1, every other set 100+address.
    function automatic int rom(input logic [4:0] a);
        return (a[4:3] == 2'd2) ? int'(a[2:0]) + 1 : 100 + int'(a);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    longint acc, xval;

    task automatic model_step();
        if (acc_init) acc = rom(coeff_addr);
        if (mac_en)   acc = acc * xval + rom(coeff_addr);
    endtask

    vec_t tv[12];

    initial begin
        int cnt2, lat, nmac, ninit, nbad;
        int q_pop[$], q_mac[$], q_ov[$], q_idx[$];
        int exp_pop[3], exp_mac[9], exp_ov[3], exp_idx[5];
        bit seen;

        // flags = {pop, ld_signal, ld_coeff, acc_init, mac_en, out_valid, busy}
        tv[0]  = '{1'b0, 7'b1000000, 0};
        tv[1]  = '{1'b1, 7'b0111001, 20};
        tv[2]  = '{1'b1, 7'b0010101, 19};
        tv[3]  = '{1'b1, 7'b0000001, 0};
        tv[4]  = '{1'b1, 7'b0010101, 18};
        tv[5]  = '{1'b1, 7'b0000001, 0};
        tv[6]  = '{1'b1, 7'b0010101, 17};
        tv[7]  = '{1'b1, 7'b0000001, 0};
        tv[8]  = '{1'b1, 7'b0010101, 16};
        tv[9]  = '{1'b1, 7'b0000001, 0};
        tv[10] = '{1'b1, 7'b0000011, 0};
        tv[11] = '{1'b1, 7'b0000000, 0};
        exp_pop = '{0, 5, 10};
        exp_ov  = '{5, 10, 15};
        exp_mac = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
        exp_idx = '{4, 3, 2, 1, 0};

        // Reset with a non-empty FIFO: no pop may leak out while rst is high.
        rst = 1'b1; fifo_empty = 1'b0; out_ready = 1'b0; func_sel = 2'd0;
        fifo_empty2 = 1'b1; out_ready2 = 1'b1; func_sel2 = 2'd1;
        acc = 0; xval = 0;
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (fifo_pop) nbad++;
        end
        chk("pop_in_reset", nbad, 0);
        @(negedge clk); rst = 1'b0; fifo_empty = 1'b1; #1;
        chk("reset_flags", flags, 0);
        chk("reset_addr", coeff_addr, 0);
        chk("reset_flags2", {fifo_pop2, mac_en2, out_valid2, busy2}, 0);

        // Empty FIFO throughout: nothing starts.
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (fifo_pop || mac_en || busy) nbad++;
        end
        chk("idle_empty_activity", nbad, 0);

        // One sample, cycle-by-cycle table, plus MAC data model.
        out_ready = 1'b1; func_sel = 2'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); fifo_empty = tv[i].empty; #1;
            if (ld_signal) xval = 2;
            chk($sformatf("tab_flags_c%0d", i), flags, tv[i].flags);
            if (tv[i].flags[4]) chk($sformatf("tab_addr_c%0d", i), coeff_addr, tv[i].addr);
            model_step();
            if (out_valid) chk("tab_result", acc, 129);
        end

        // MAC_LAT=1, ORDER=3 stream of three samples.
        cnt2 = 3;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); fifo_empty2 = (cnt2 == 0); #1;
            if (fifo_pop2) begin q_pop.push_back(t); cnt2--; end
            if (mac_en2)    q_mac.push_back(t);
            if (out_valid2) q_ov.push_back(t);
        end
        chk("l1_pop_count", q_pop.size(), 3);
        chk("l1_mac_count", q_mac.size(), 9);
        chk("l1_ov_count", q_ov.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("l1_pop_cyc%0d", i), (i < q_pop.size()) ? q_pop[i] : -1, exp_pop[i]);
            chk($sformatf("l1_ov_cyc%0d", i), (i < q_ov.size()) ? q_ov[i] : -1, exp_ov[i]);
        end
        for (int i = 0; i < 9; i++)
            chk($sformatf("l1_mac_cyc%0d", i), (i < q_mac.size()) ? q_mac[i] : -1, exp_mac[i]);
        chk("l1_busy_end", busy2, 0);

        // Backpressure: FIFO stays non-empty while out_ready is low.
        fifo_empty = 1'b0; out_ready = 1'b0; func_sel = 2'd1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_reach_out", seen, 1);
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_hold%0d", i), {out_valid, fifo_pop}, 2'b10);
        end
        @(negedge clk); out_ready = 1'b1; func_sel = 2'd3; #1;
        chk("bp_handshake_pop", {out_valid, fifo_pop}, 2'b11);

        // Second sample with func_sel toggling: addresses keep the captured set 3.
        seen = 1'b0; acc = 0; nmac = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk); fifo_empty = 1'b1; func_sel = t[0] ? 2'd1 : 2'd0; #1;
            if (ld_signal) xval = 3;
            if (fifo_pop) nmac += 100;
            if (ld_coeff) begin
                chk($sformatf("fs_func_t%0d", t), coeff_addr[4:3], 3);
                q_idx.push_back(int'(coeff_addr[2:0]));
            end
            model_step();
            if (out_valid) seen = 1'b1;
        end
        chk("fs_reach_out", seen, 1);
        chk("fs_no_extra_pop", nmac, 0);
        chk("fs_result", acc, 15430);
        chk("fs_idx_count", q_idx.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fs_idx%0d", i), (i < q_idx.size()) ? q_idx[i] : -1, exp_idx[i]);
        @(negedge clk); #1;
        chk("fs_back_idle", busy, 0);

        // Reset asserted while in WAIT.
        func_sel = 2'd2;
        @(negedge clk); fifo_empty = 1'b0; #1;
        chk("rst_pop", fifo_pop, 1);
        @(negedge clk); fifo_empty = 1'b1; #1;
        @(negedge clk); #1;
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_in_wait", {busy, mac_en, ld_coeff}, 3'b100);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_flags_after", flags, 0);

        // Fresh sample after reset: latency, pulse counts and value.
        lat = -1; nmac = 0; ninit = 0; acc = 0;
        for (int t = 0; t < 30 && lat < 0; t++) begin
            @(negedge clk); fifo_empty = (t != 0); #1;
            if (ld_signal) xval = 2;
            if (mac_en) nmac++;
            if (acc_init) ninit++;
            model_step();
            if (out_valid) lat = t;
        end
        chk("rst_fresh_latency", lat, 10);
        chk("rst_fresh_mac_count", nmac, 4);
        chk("rst_fresh_init_count", ninit, 1);
        chk("rst_fresh_result", acc, 129);
        @(negedge clk); #1;
        chk("rst_fresh_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
